// File: rtl/team_06_audio_pkg.sv
// team_06_audio_pkg: shared sample format and I2S receiver state encoding for the effects chain
package team_06_audio_pkg;
    localparam int AUDIO_W = 8;
    localparam logic [AUDIO_W-1:0] AUDIO_MIDSCALE = 8'h80;
    typedef enum logic [1:0] {IDLE, SKIP, CAPTURE, WAIT_WS} i2s_rx_state_t;
endpackage

// File: rtl/team_06_sync_edge.sv
// team_06_sync_edge: 2-FF synchroniser for one edge-detected line plus W data-only lines
module team_06_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         edge_in,
    input  logic [W-1:0] data_in,
    output logic         rise,
    output logic [W-1:0] data_s
);
    logic [W:0] meta_q, meta_d, sync_q, sync_d;
    logic       dly_q, dly_d;

    always_comb begin
        meta_d = {data_in, edge_in};
        sync_d = meta_q;
        dly_d  = sync_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign rise   = sync_q[0] & ~dly_q;
    assign data_s = sync_q[W:1];
endmodule

// File: rtl/team_06_i2s_rx.sv
// team_06_i2s_rx: oversampling I2S receiver producing 8-bit offset-binary samples with valid strobe
module team_06_i2s_rx
    import team_06_audio_pkg::*;
#(
    parameter int SLOT_BITS = 32,
    parameter int DATA_BITS = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               i2s_bclk,
    input  logic               i2s_ws,
    input  logic               i2s_sd,
    output logic [AUDIO_W-1:0] sample_out,
    output logic               sample_valid,
    output logic               sample_ch,
    output logic               frame_err
);
    localparam int CW = $clog2(SLOT_BITS + 2);

    logic bclk_rise, ws_s, sd_s;
    logic ws_edge, slot_over;
    logic [DATA_BITS-1:0] shift_w;

    i2s_rx_state_t        state_q, state_d;
    logic                 chan_q, chan_d, ws_prev_q, ws_prev_d;
    logic [DATA_BITS-2:0] shreg_q, shreg_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d, slot_cnt_q, slot_cnt_d;
    logic [AUDIO_W-1:0]   sample_out_q, sample_out_d;
    logic                 sample_valid_q, sample_valid_d, sample_ch_q, sample_ch_d;
    logic                 frame_err_q, frame_err_d;

    team_06_sync_edge #(.W(2)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .edge_in(i2s_bclk),
        .data_in({i2s_sd, i2s_ws}),
        .rise   (bclk_rise),
        .data_s ({sd_s, ws_s})
    );

    always_comb begin
        state_d        = state_q;
        chan_d         = chan_q;
        ws_prev_d      = ws_prev_q;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        slot_cnt_d     = slot_cnt_q;
        sample_out_d   = sample_out_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        ws_edge        = ws_s ^ ws_prev_q;
        slot_over      = !ws_edge && (slot_cnt_q == CW'(SLOT_BITS));
        shift_w        = {shreg_q, sd_s};
        if (!en) begin
            state_d = IDLE;
        end else if (bclk_rise) begin
            ws_prev_d  = ws_s;
            // saturates once past the overflow point so a stuck WS never wraps
            slot_cnt_d = ws_edge ? '0 :
                         (slot_cnt_q == CW'(SLOT_BITS + 1)) ? slot_cnt_q : slot_cnt_q + 1'b1;
            if (ws_edge && state_q != SKIP) begin
                frame_err_d = (state_q == CAPTURE);
                shreg_d     = '0;
                chan_d      = ws_s;
                state_d     = SKIP;
            end else if (slot_over && (state_q == CAPTURE || state_q == WAIT_WS)) begin
                frame_err_d = 1'b1;
                state_d     = IDLE;
            end else if (state_q == SKIP) begin
                bit_cnt_d = '0;
                state_d   = CAPTURE;
            end else if (state_q == CAPTURE) begin
                shreg_d   = shift_w[DATA_BITS-2:0];
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == CW'(DATA_BITS - 1)) begin
                    sample_out_d   = {~shift_w[DATA_BITS-1], shift_w[DATA_BITS-2 -: AUDIO_W-1]};
                    sample_ch_d    = chan_q;
                    sample_valid_d = 1'b1;
                    state_d        = WAIT_WS;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            chan_q         <= 1'b0;
            ws_prev_q      <= 1'b0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            slot_cnt_q     <= '0;
            sample_out_q   <= AUDIO_MIDSCALE;
            sample_ch_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            ws_prev_q      <= ws_prev_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            slot_cnt_q     <= slot_cnt_d;
            sample_out_q   <= sample_out_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign frame_err    = frame_err_q;
endmodule
